dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-stage responder for the five-stage pipeline. Consumes the memory request emitted by the execute-to-memory pipeline register (read/write strobes, ALU-computed address, store data, writeback sideband), performs the access on an internal word-addressed SRAM with a configurable number of wait states, and presents load data plus sideband to the memory-to-writeback register. It raises `stall_out` so upstream stages hold the request while the access is in flight.

## Interface
- `ADDR_W`, 10: word-address width; memory depth is 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 1: extra cycles per memory access, range 0–15.

- `clk`  in  1  rising-edge clock. The upstream pipeline register updates on the falling edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `mem_read_in`  in  1  load request.
- `mem_write_in`  in  1  store request.
- `addr_in`  in  32  byte address, which is the ALU result.
- `wdata_in`  in  32  store data.
- `rd_in`  in  5  destination register.
- `reg_write_in`, `mem_to_reg_in`  in  1 each  writeback controls.
- `stall_out`  out  1  hold upstream registers.
- `valid_out`  out  1  one-cycle pulse: a memory access completed.
- `rdata_out`  out  32  load data.
- `alu_result_out`  out  32  captured `addr_in`, for non-load writeback.
- `rd_out`  out  5  captured `rd_in`.
- `reg_write_out`, `mem_to_reg_out`  out  1 each  captured writeback controls.
- `err_out`  out  1  one-cycle pulse: the request was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **Request classification at each rising edge**, in IDLE or RESP:
  - A request is `mem_read_in | mem_write_in`.
  - It is an error if both strobes are high, if `addr_in[1:0] != 0`, or if `addr_in[31:ADDR_W+2] != 0`.
  - Word index is `addr_in[ADDR_W+1:2]`.
- **Valid request, WAIT_CYCLES > 0:** capture address, data, and sideband; load counter with `WAIT_CYCLES-1`; go to WAIT.
- **Valid request, WAIT_CYCLES = 0:** perform the access at this edge; go to RESP.
- **WAIT:**
  - Counter nonzero: decrement.
  - Counter zero: perform the access (write commits, or read data latches into `rdata_out`), then go to RESP.
- **RESP:**
  - `valid_out` = 1.
  - The next edge treats the inputs as a new request, so the FSM can go back-to-back to WAIT or RESP. With no request it returns to IDLE.
- **Non-memory instruction** (neither strobe high): sideband is registered at the edge with `valid_out` = 0, `rdata_out` unchanged, state goes to IDLE. Pass-through latency is 1 cycle.
- **Error request:**
  - No memory access.
  - `err_out` pulses for one cycle.
  - `reg_write_out` is forced to 0 and `rdata_out` to 0.
  - Go to IDLE. No stall.
- `rdata_out` holds its value until the next read completes.
- SRAM contents are not reset.

## Timing
- `stall_out` is combinational:
  - high in WAIT;
  - high in IDLE or RESP when a valid request is present and WAIT_CYCLES > 0;
  - low otherwise, and always low in RESP when no new request is present.
- **Latency:** a request accepted at edge N gives `valid_out` high in the cycle after edge N+WAIT_CYCLES. Stores commit at edge N+WAIT_CYCLES.
- **Stall release:** `stall_out` falls in the RESP cycle, so the upstream register advances on that cycle's falling edge. This guarantees a held request is never accepted twice.
- **Reset value of every output:** `stall_out`, `valid_out`, `err_out`, `reg_write_out`, and `mem_to_reg_out` = 0; `rdata_out`, `alu_result_out`, and `rd_out` = 0. State = IDLE, counter = 0.
- **Reset mid-operation:** the FSM goes to IDLE immediately. A store still in WAIT is discarded and memory is unchanged. A store already committed remains.
- **Simultaneous strobes:** treated as an error, not as priority.

## Structure
- Package `dmem_pkg`:
  - `dmem_state_t` enum {IDLE, WAIT, RESP};
  - `WORD_BYTES` = 4;
  - the address-check helper function.
- Sub-module `dmem_sram`: single-port synchronous word array (`ADDR_W` x 32) with write enable; the read is registered at the clock edge.
- Top level: FSM, wait counter, capture registers, error checks.

## Test plan
- WAIT_CYCLES=1: store 0xDEADBEEF to addr 0x10, then load addr 0x10 with rd=5 -> each access gives `stall_out` high for 2 cycles; the load gives `valid_out` with `rdata_out`=0xDEADBEEF, `rd_out`=5, `mem_to_reg_out`=1.
- WAIT_CYCLES=0: back-to-back loads of 0x0 and 0x4 (preloaded 1 and 2) -> no stall; `valid_out` high on 2 consecutive cycles with data 1 then 2.
- Load addr 0x13 -> `err_out` pulse, `reg_write_out`=0, no stall. Load addr 0x00001000 with ADDR_W=10 -> `err_out`. Both strobes high -> `err_out`, memory unchanged.
- WAIT_CYCLES=3: assert `reset` during the WAIT of a store 0x55 to 0x20 -> outputs zero at once; a later load of 0x20 returns the old value.
- Non-memory op with ALU result 0x1234, rd=7, reg_write=1 -> one cycle later `alu_result_out`=0x1234, `rd_out`=7, `reg_write_out`=1, `valid_out`=0.
- Load held by the upstream register while `stall_out` is high -> exactly one `valid_out` pulse per request.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the memory-stage responder.
// Holds the FSM state encoding, word size and the address legality check.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_t;

   localparam int unsigned WORD_BYTES = 4;

   // Legal when word aligned and no bits set above the implemented word index.
   function automatic logic addr_ok(input logic [31:0] addr, input int unsigned addr_w);
      logic [31:0] w_hi;
      w_hi = addr >> (addr_w + 2);
      return ((addr & 32'(WORD_BYTES - 1)) == '0) && (w_hi == '0);
   endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous word array with a registered read port.
// The read register holds until the next read and can be cleared; the array itself is not reset.
module dmem_sram #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_en,
   input  logic              i_we,
   input  logic              i_clr,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata
);

   logic [31:0] r_mem [2**ADDR_W];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_en && i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata <= '0;
      end else if (i_clr) begin
         r_rdata <= '0;
      end else if (i_en && !i_we) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: classifies the EX/MEM request, runs the SRAM access with
// configurable wait states and presents load data plus writeback sideband to MEM/WB.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   input  logic [4:0]  rd_in,
   input  logic        reg_write_in,
   input  logic        mem_to_reg_in,
   output logic        stall_out,
   output logic        valid_out,
   output logic [31:0] rdata_out,
   output logic [31:0] alu_result_out,
   output logic [4:0]  rd_out,
   output logic        reg_write_out,
   output logic        mem_to_reg_out,
   output logic        err_out
);

   localparam logic       HAS_WAIT = (WAIT_CYCLES != 0);
   localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   dmem_state_t r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;

   logic [31:0] r_alu;
   logic [31:0] r_wdata;
   logic        r_is_write;
   logic [4:0]  r_rd;
   logic        r_rw;
   logic        r_mtr;
   logic        r_err;
   logic        r_adv;

   logic              w_req;
   logic              w_err;
   logic              w_accept;
   logic              w_stall;
   logic              w_mem_en;
   logic              w_mem_we;
   logic              w_clr;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [31:0]       w_mem_wdata;
   logic [31:0]       w_rdata;

   assign w_req    = mem_read_in | mem_write_in;
   assign w_err    = w_req & ((mem_read_in & mem_write_in) | ~addr_ok(addr_in, ADDR_W));
   assign w_accept = w_req & ~w_err;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stall     = 1'b0;
      w_mem_en    = 1'b0;
      w_mem_we    = 1'b0;
      w_clr       = 1'b0;
      w_mem_addr  = addr_in[ADDR_W+1:2];
      w_mem_wdata = wdata_in;
      case (r_state)
         WAIT: begin
            w_stall = 1'b1;
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_mem_en    = 1'b1;
               w_mem_we    = r_is_write;
               w_mem_addr  = r_alu[ADDR_W+1:2];
               w_mem_wdata = r_wdata;
               w_state_nxt = RESP;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            if (w_err) begin
               w_clr = 1'b1;
            end else if (w_accept) begin
               if (HAS_WAIT) begin
                  w_cnt_nxt   = CNT_INIT;
                  w_state_nxt = WAIT;
                  // In RESP the inputs still carry the request just served until the
                  // upstream advances on the falling edge; only stall after that.
                  w_stall     = (r_state == IDLE) || r_adv;
               end else begin
                  w_mem_en    = 1'b1;
                  w_mem_we    = mem_write_in;
                  w_state_nxt = RESP;
               end
            end
         end
      endcase
      if (reset) begin
         w_mem_en = 1'b0;
         w_stall  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_alu      <= '0;
         r_wdata    <= '0;
         r_is_write <= 1'b0;
         r_rd       <= '0;
         r_rw       <= 1'b0;
         r_mtr      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= 1'b0;
         if (r_state != WAIT) begin
            r_alu      <= addr_in;
            r_wdata    <= wdata_in;
            r_is_write <= mem_write_in;
            r_rd       <= rd_in;
            r_rw       <= reg_write_in & ~w_err;
            r_mtr      <= mem_to_reg_in;
            r_err      <= w_err;
         end
      end
   end

   // Marks that the upstream register has had its falling edge inside RESP.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         r_adv <= 1'b0;
      end else begin
         r_adv <= (r_state == RESP);
      end
   end

   dmem_sram #(.ADDR_W(ADDR_W)) u_sram (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_mem_en),
      .i_we    (w_mem_we),
      .i_clr   (w_clr),
      .i_addr  (w_mem_addr),
      .i_wdata (w_mem_wdata),
      .o_rdata (w_rdata)
   );

   assign stall_out      = w_stall;
   assign valid_out      = (r_state == RESP);
   assign rdata_out      = w_rdata;
   assign alu_result_out = r_alu;
   assign rd_out         = r_rd;
   assign reg_write_out  = r_rw;
   assign mem_to_reg_out = r_mtr;
   assign err_out        = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (0, 1 and 3 wait states) each driven
// by an upstream-register model; expected responses come from a transaction-level reference.
module tb_dmem_responder;

   localparam int unsigned AW = 10;

   typedef struct {
      int          due;
      logic        valid;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        rw;
      logic        mtr;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   function automatic void chk(input string name, input int lane_id,
                               input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL lane%0d %s: got %h expected %h", lane_id, name, act, exp);
      end
   endfunction

   for (genvar g = 0; g < 3; g++) begin : lane
      localparam int unsigned WC = (g == 0) ? 0 : (g == 1) ? 1 : 3;

      logic        rst;
      logic        rd_en, wr_en, rw_in, mtr_in;
      logic [31:0] addr, wdata;
      logic [4:0]  rdi;
      logic        stall, valid, err, rw_o, mtr_o;
      logic [31:0] rdata, alu;
      logic [4:0]  rd_o;
      logic        done = 1'b0;

      exp_t        q[$];
      logic [31:0] mem [int];
      logic [31:0] last_rd;

      dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) u_dut (
         .clk            (clk),
         .reset          (rst),
         .mem_read_in    (rd_en),
         .mem_write_in   (wr_en),
         .addr_in        (addr),
         .wdata_in       (wdata),
         .rd_in          (rdi),
         .reg_write_in   (rw_in),
         .mem_to_reg_in  (mtr_in),
         .stall_out      (stall),
         .valid_out      (valid),
         .rdata_out      (rdata),
         .alu_result_out (alu),
         .rd_out         (rd_o),
         .reg_write_out  (rw_o),
         .mem_to_reg_out (mtr_o),
         .err_out        (err)
      );

      task automatic check_zero(input string tag);
         chk({tag, "_stall"}, g, 32'(stall), 32'd0);
         chk({tag, "_valid"}, g, 32'(valid), 32'd0);
         chk({tag, "_err"}, g, 32'(err), 32'd0);
         chk({tag, "_rdata"}, g, rdata, 32'd0);
         chk({tag, "_alu"}, g, alu, 32'd0);
         chk({tag, "_rd"}, g, 32'(rd_o), 32'd0);
         chk({tag, "_rw"}, g, 32'(rw_o), 32'd0);
         chk({tag, "_mtr"}, g, 32'(mtr_o), 32'd0);
      endtask

      task automatic idle_inputs();
         rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
         rdi = '0; rw_in = 1'b0; mtr_in = 1'b0;
      endtask

      // Called at a falling edge: the upstream register presents one instruction.
      task automatic present(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [4:0] rn,
                             input logic rwv, input logic mtrv, input bit follow);
         exp_t e;
         bit   bad, memop;
         int   held;
         logic s;
         rd_en = r; wr_en = w; addr = a; wdata = d; rdi = rn; rw_in = rwv; mtr_in = mtrv;
         bad   = (r && w) || (a % 4 != 0) || (a >= (32'd4 << AW));
         memop = (r || w) && !bad;
         e.due   = cyc + 1 + (memop ? int'(WC) : 0);
         e.valid = memop;
         e.err   = (r || w) && bad;
         e.alu   = a;
         e.rd    = rn;
         e.mtr   = mtrv;
         e.rw    = e.err ? 1'b0 : rwv;
         if (e.err) last_rd = '0;
         else if (memop && r) last_rd = mem[int'(a >> 2)];
         else if (memop && w) mem[int'(a >> 2)] = d;
         e.rdata = last_rd;
         q.push_back(e);
         #4;
         chk("stall_req", g, 32'(stall), 32'(memop && (WC > 0)));
         if (follow) begin
            held = 0;
            forever begin
               @(posedge clk); #4; s = stall; @(negedge clk);
               if (!s) break;
               held++;
               if (held > 40) begin
                  chk("stall_timeout", g, 32'(held), 32'd0);
                  break;
               end
            end
            chk("stall_len", g, 32'(held), memop ? 32'(WC) : 32'd0);
         end
      endtask

      task automatic drain();
         int k;
         idle_inputs();
         k = 0;
         while (q.size() > 0 && k < 60) begin
            @(negedge clk);
            k++;
         end
         chk("drain", g, 32'(q.size()), 32'd0);
      endtask

      // Monitor: pops an entry on its due cycle, otherwise requires no pulses.
      initial begin
         exp_t e;
         forever begin
            @(posedge clk); #1;
            if (!rst) begin
               if (q.size() > 0 && q[0].due == cyc) begin
                  e = q.pop_front();
                  chk("valid", g, 32'(valid), 32'(e.valid));
                  chk("err", g, 32'(err), 32'(e.err));
                  chk("rdata", g, rdata, e.rdata);
                  chk("alu", g, alu, e.alu);
                  chk("rd", g, 32'(rd_o), 32'(e.rd));
                  chk("reg_write", g, 32'(rw_o), 32'(e.rw));
                  chk("mem_to_reg", g, 32'(mtr_o), 32'(e.mtr));
               end else begin
                  chk("valid_idle", g, 32'(valid), 32'd0);
                  chk("err_idle", g, 32'(err), 32'd0);
               end
            end
         end
      end

      initial begin
         logic [31:0] old;
         int          acc;
         rst = 1'b1;
         last_rd = '0;
         idle_inputs();
         repeat (2) @(negedge clk);
         check_zero("reset");
         rst = 1'b0;
         @(negedge clk);

         present(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1);
         present(1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1);
         for (int i = 0; i < 16; i++)
            present(1'b0, 1'b1, 32'(i * 4), (i < 2) ? 32'(i + 1) : $urandom, 5'(i), 1'b0, 1'b0, 1'b1);
         present(1'b1, 1'b0, 32'h0, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1);
         present(1'b1, 1'b0, 32'h4, 32'h0, 5'd2, 1'b1, 1'b1, 1'b1);
         present(1'b1, 1'b0, 32'h13, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1);
         present(1'b1, 1'b0, 32'h1000, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1);
         present(1'b1, 1'b1, 32'h0C, 32'hBADBAD00, 5'd6, 1'b1, 1'b0, 1'b1);
         present(1'b1, 1'b0, 32'h0C, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1);
         present(1'b0, 1'b0, 32'h1234, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);

         for (int i = 0; i < 150; i++) begin
            int unsigned kind;
            int unsigned sh;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            a    = 32'($urandom_range(0, 15)) << 2;
            case (kind)
               0, 1, 2, 3: present(1'b1, 1'b0, a, $urandom, 5'($urandom), 1'($urandom), 1'b1, 1'b1);
               4, 5, 6:    present(1'b0, 1'b1, a, $urandom, 5'($urandom), 1'b0, 1'b0, 1'b1);
               7:          present(1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'b1);
               8: begin
                  if ($urandom_range(0, 1) == 0) begin
                     a = a | 32'($urandom_range(1, 3));
                  end else begin
                     sh = $urandom_range(AW + 2, 31);
                     a  = a | (32'h1 << sh);
                  end
                  present(1'($urandom), ~rd_en, a, $urandom, 5'($urandom), 1'b1, 1'($urandom), 1'b1);
               end
               default:    present(1'b1, 1'b1, a, $urandom, 5'($urandom), 1'b1, 1'($urandom), 1'b1);
            endcase
         end
         drain();

         @(negedge clk);
         old = mem[8];
         acc = cyc + 1;
         present(1'b0, 1'b1, 32'h20, 32'h55, 5'd9, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
         rst = 1'b1;
         #1;
         check_zero("reset_mid");
         if (acc + int'(WC) > cyc) mem[8] = old;
         q.delete();
         last_rd = '0;
         idle_inputs();
         repeat (2) @(negedge clk);
         rst = 1'b0;
         @(negedge clk);
         present(1'b1, 1'b0, 32'h20, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1);
         drain();
         done = 1'b1;
      end
   end

   initial begin
      int t;
      t = 0;
      while (!(lane[0].done && lane[1].done && lane[2].done) && t < 20000) begin
         @(posedge clk);
         t++;
      end
      chk("finish_budget", 0, 32'(t < 20000), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
